bank_cmd_fsm: RTL and testbench
===============================

# bank_cmd_fsm

Per-bank command tracker that sits directly upstream of the MEMSync stage. One instance per bank. It decodes bank-selected DDR commands (ACT/RD/WR/PRE/REF) into the 5-bit bank state code, the open row id, and the one-cycle `sync` pulse that MEMSync consumes. It also honours MEMSync's `stall` back-pressure. It enforces tRCD/tCL/tCWL/tBL/tRP/tRFC in clock cycles and flags illegal commands.

## Interface
- ADDRWIDTH, 17, row address width
- TRCD, 4, ACT-to-RD/WR cycles (≥1)
- TCL, 4, read latency cycles (≥1)
- TCWL, 3, write latency cycles (≥1)
- TBL, 4, burst cycles (≥1)
- TRP, 4, precharge cycles (≥1)
- TRFC, 8, refresh cycles (≥1); every latency sum ≤255 (8-bit counter)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high (already decided)
- sel  in  1  command addresses this bank (bg/ba match done outside)
- cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF; 6/7 treated as NOP
- row  in  ADDRWIDTH  row address, sampled with ACT
- stall  in  1  MEMSync back-pressure
- BankFSM  out  5  state code to MEMSync
- RowId  out  ADDRWIDTH  open row
- sync  out  1  one-cycle pulse at first data beat of RD/WR
- cmd_err  out  1  one-cycle pulse for an illegal command

## Operation
- State codes on BankFSM: IDLE 5'b00000, ACTIVATING 5'b00001, ACTIVE 5'b00010, PRECHARGING 5'b00100, REFRESHING 5'b01000, READING 5'b01011, WRITING 5'b10010.
- A command counts only when sel=1 and cmd≠NOP. All other cycles are NOP.
- IDLE:
  - ACT → ACTIVATING; RowId←row.
  - REF → REFRESHING.
  - PRE is a legal no-op.
  - RD/WR → cmd_err; stay in IDLE.
- ACTIVATING lasts TRCD cycles, then goes to ACTIVE. Any command here → cmd_err.
- ACTIVE:
  - RD → READING.
  - WR → WRITING.
  - PRE → PRECHARGING.
  - ACT/REF → cmd_err; RowId unchanged.
- READING/WRITING:
  - Beat index k starts at 0. L=TCL for READING, TCWL for WRITING.
  - k advances each cycle that stall=0. It holds while stall=1.
  - sync=1 in the cycle where k==L and stall=0.
  - The state exits to ACTIVE after k reaches L+TBL−1 and advances.
  - Any command during a burst → cmd_err. No command pipelining.
- PRECHARGING lasts TRP cycles, then goes to IDLE. REFRESHING lasts TRFC cycles, then goes to IDLE. Commands in either state → cmd_err.
- RowId holds its last value through PRE/REF. It changes only on a legal ACT.
- stall affects only READING/WRITING. It is ignored in every other state.

## Timing
- Reset values: BankFSM=00000, RowId=0, sync=0, cmd_err=0, k and counters=0.
- reset asserted mid-operation returns the block to IDLE immediately and asynchronously. The first command is accepted on the first rising edge after deassertion.
- A command is sampled at edge E. The new state and RowId are visible after E. cmd_err is high for exactly the cycle following E.
- Dwell times with no stall:
  - ACTIVATING: exactly TRCD cycles.
  - READING: TCL+TBL cycles.
  - WRITING: TCWL+TBL cycles.
  - PRECHARGING: TRP cycles.
  - REFRESHING: TRFC cycles.
- Each stalled cycle inside READING/WRITING extends the dwell by 1.
- sync is high for exactly one cycle per RD/WR. It is never high outside READING/WRITING.
- Dwell boundary: a command arriving in the last cycle of a timed state is still illegal (cmd_err). It becomes legal one cycle later.
- Stall boundary: if stall rises in the cycle where k==L, sync is withheld. It fires in the first cycle with stall=0.

## Test plan
- Reset, then sel=1 ACT row=0x1A2B3 → BankFSM=00001 for 4 cycles, then 00010; RowId=0x1A2B3.
- From ACTIVE, WR → BankFSM=10010 for 7 cycles; sync high only in the 4th cycle (k=3); returns to 00010.
- From ACTIVE, RD with stall=1 held for 3 cycles starting at k=4 → sync delayed 3 cycles; READING lasts 11 cycles; single sync pulse.
- RD in IDLE, ACT during ACTIVATING, WR during READING → cmd_err one pulse each; state and RowId unaffected.
- PRE from ACTIVE → 00100 for 4 cycles, then IDLE with RowId retained. REF → 01000 for 8 cycles, then 00000.
- Assert reset in the middle of WRITING (k=2) → outputs go to zero asynchronously with no sync. After release, ACT is accepted normally.

Source files
------------

// File: rtl/bank_cmd_fsm.sv
// Per-bank DDR command tracker: decodes ACT/RD/WR/PRE/REF into bank state, open row and a data-sync pulse.
// Latency: state/RowId/cmd_err update one edge after the command; sync is combinational on the first data beat.
// Backpressure: stall freezes the burst beat counter in READING/WRITING only; ignored elsewhere.
module bank_cmd_fsm #(
    parameter int ADDRWIDTH = 17,
    parameter int TRCD      = 4,
    parameter int TCL       = 4,
    parameter int TCWL      = 3,
    parameter int TBL       = 4,
    parameter int TRP       = 4,
    parameter int TRFC      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic [2:0]           cmd,
    input  logic [ADDRWIDTH-1:0] row,
    input  logic                 stall,
    output logic [4:0]           BankFSM,
    output logic [ADDRWIDTH-1:0] RowId,
    output logic                 sync,
    output logic                 cmd_err
);

    typedef enum logic [4:0] {
        IDLE        = 5'b00000,
        ACTIVATING  = 5'b00001,
        ACTIVE      = 5'b00010,
        PRECHARGING = 5'b00100,
        REFRESHING  = 5'b01000,
        READING     = 5'b01011,
        WRITING     = 5'b10010
    } state_t;

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam logic [7:0] TRCD_M1  = 8'(TRCD - 1);
    localparam logic [7:0] TRP_M1   = 8'(TRP - 1);
    localparam logic [7:0] TRFC_M1  = 8'(TRFC - 1);
    localparam logic [7:0] RD_DATA  = 8'(TCL);
    localparam logic [7:0] WR_DATA  = 8'(TCWL);
    localparam logic [7:0] RD_LAST  = 8'(TCL + TBL - 1);
    localparam logic [7:0] WR_LAST  = 8'(TCWL + TBL - 1);

    state_t                 state_q;
    logic [ADDRWIDTH-1:0]   row_q;
    logic [7:0]             cnt_q;
    logic                   cmd_err_q;

    logic                   cmd_vld;
    logic                   in_burst;
    logic [7:0]             beat_data;
    logic [7:0]             beat_last;

    assign cmd_vld = sel && (cmd != 3'd0) && (cmd <= CMD_REF);

    // cnt_q counts down in timed states and is the beat index k in bursts.
    always_comb begin
        in_burst  = (state_q == READING) || (state_q == WRITING);
        beat_data = (state_q == WRITING) ? WR_DATA : RD_DATA;
        beat_last = (state_q == WRITING) ? WR_LAST : RD_LAST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            cnt_q     <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_vld) begin
                        case (cmd)
                            CMD_ACT: begin
                                state_q <= ACTIVATING;
                                row_q   <= row;
                                cnt_q   <= TRCD_M1;
                            end
                            CMD_REF: begin
                                state_q <= REFRESHING;
                                cnt_q   <= TRFC_M1;
                            end
                            CMD_PRE: ;
                            default: cmd_err_q <= 1'b1;
                        endcase
                    end
                end
                ACTIVE: begin
                    if (cmd_vld) begin
                        case (cmd)
                            CMD_RD: begin
                                state_q <= READING;
                                cnt_q   <= '0;
                            end
                            CMD_WR: begin
                                state_q <= WRITING;
                                cnt_q   <= '0;
                            end
                            CMD_PRE: begin
                                state_q <= PRECHARGING;
                                cnt_q   <= TRP_M1;
                            end
                            default: cmd_err_q <= 1'b1;
                        endcase
                    end
                end
                READING, WRITING: begin
                    cmd_err_q <= cmd_vld;
                    if (!stall) begin
                        if (cnt_q == beat_last) begin
                            state_q <= ACTIVE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                ACTIVATING, PRECHARGING, REFRESHING: begin
                    cmd_err_q <= cmd_vld;
                    if (cnt_q == 8'd0) begin
                        state_q <= (state_q == ACTIVATING) ? ACTIVE : IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign BankFSM = state_q;
    assign RowId   = row_q;
    assign cmd_err = cmd_err_q;
    assign sync    = in_burst && (cnt_q == beat_data) && !stall;

endmodule

// File: tb/tb_bank_cmd_fsm.sv
// Bench for bank_cmd_fsm: directed vector table, hand-written reset corner, and random traffic
// compared against a schedule-queue reference model.
module tb_bank_cmd_fsm;

    localparam int AW   = 17;
    localparam int TRCD = 4;
    localparam int TCL  = 4;
    localparam int TCWL = 3;
    localparam int TBL  = 4;
    localparam int TRP  = 4;
    localparam int TRFC = 8;

    localparam logic [4:0] S_IDLE  = 5'b00000;
    localparam logic [4:0] S_ACTG  = 5'b00001;
    localparam logic [4:0] S_ACT   = 5'b00010;
    localparam logic [4:0] S_PRE   = 5'b00100;
    localparam logic [4:0] S_REF   = 5'b01000;
    localparam logic [4:0] S_RD    = 5'b01011;
    localparam logic [4:0] S_WR    = 5'b10010;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;
    localparam logic [2:0] C_REF = 3'd5;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel;
    logic [2:0]    cmd;
    logic [AW-1:0] row;
    logic          stall;
    logic [4:0]    BankFSM;
    logic [AW-1:0] RowId;
    logic          sync;
    logic          cmd_err;

    int n_checks = 0;
    int n_pass   = 0;

    bank_cmd_fsm #(
        .ADDRWIDTH(AW), .TRCD(TRCD), .TCL(TCL), .TCWL(TCWL),
        .TBL(TBL), .TRP(TRP), .TRFC(TRFC)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .cmd(cmd), .row(row), .stall(stall),
        .BankFSM(BankFSM), .RowId(RowId), .sync(sync), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of future state codes; empty queue means the bank rests in IDLE or ACTIVE.
    logic [4:0]    m_q[$];
    bit            m_sy[$];
    bit            m_open;
    logic [AW-1:0] m_row;
    bit            m_err;

    function automatic logic [4:0] m_state();
        if (m_q.size() != 0) return m_q[0];
        return m_open ? S_ACT : S_IDLE;
    endfunction

    function automatic void m_push(input logic [4:0] code, input int n, input int sync_idx);
        for (int i = 0; i < n; i++) begin
            m_q.push_back(code);
            m_sy.push_back(i == sync_idx);
        end
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_sy.delete();
        m_open = 1'b0;
        m_row  = '0;
        m_err  = 1'b0;
    endfunction

    function automatic void m_step(input logic s, input logic [2:0] c, input logic [AW-1:0] r, input logic st);
        bit issued;
        issued = s && (c >= C_ACT) && (c <= C_REF);
        m_err  = 1'b0;
        if (m_q.size() != 0) begin
            if (issued) m_err = 1'b1;
            if (!(st && (m_q[0] == S_RD || m_q[0] == S_WR))) begin
                void'(m_q.pop_front());
                void'(m_sy.pop_front());
            end
        end else if (issued) begin
            if (!m_open) begin
                if (c == C_ACT) begin
                    m_push(S_ACTG, TRCD, -1);
                    m_open = 1'b1;
                    m_row  = r;
                end else if (c == C_REF) m_push(S_REF, TRFC, -1);
                else if (c != C_PRE) m_err = 1'b1;
            end else begin
                if (c == C_RD) m_push(S_RD, TCL + TBL, TCL);
                else if (c == C_WR) m_push(S_WR, TCWL + TBL, TCWL);
                else if (c == C_PRE) begin
                    m_push(S_PRE, TRP, -1);
                    m_open = 1'b0;
                end else m_err = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic s, input logic [2:0] c, input logic [AW-1:0] r, input logic st);
        sel = s; cmd = c; row = r; stall = st;
    endtask

    // Called at a negedge: drive, check the current cycle, move to the next negedge.
    task automatic step_exp(input logic s, input logic [2:0] c, input logic [AW-1:0] r, input logic st,
                            input logic [4:0] e_st, input logic [AW-1:0] e_row,
                            input logic e_sy, input logic e_er, input string tag);
        drive(s, c, r, st);
        #1;
        chk({tag, ".state"}, 32'(BankFSM), 32'(e_st));
        chk({tag, ".row"},   32'(RowId),   32'(e_row));
        chk({tag, ".sync"},  32'(sync),    32'(e_sy));
        chk({tag, ".err"},   32'(cmd_err), 32'(e_er));
        @(negedge clk);
    endtask

    task automatic step_model(input logic s, input logic [2:0] c, input logic [AW-1:0] r, input logic st);
        drive(s, c, r, st);
        #1;
        chk("rnd.state", 32'(BankFSM), 32'(m_state()));
        chk("rnd.row",   32'(RowId),   32'(m_row));
        chk("rnd.sync",  32'(sync),    32'(m_q.size() != 0 && m_sy[0] && !st));
        chk("rnd.err",   32'(cmd_err), 32'(m_err));
        m_step(s, c, r, st);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, C_NOP, '0, 1'b0);
        #1;
        chk("rst.state", 32'(BankFSM), 32'h0);
        chk("rst.row",   32'(RowId),   32'h0);
        chk("rst.sync",  32'(sync),    32'h0);
        chk("rst.err",   32'(cmd_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic          sel;
        logic [2:0]    cmd;
        logic [AW-1:0] row;
        logic          stall;
        int            reps;
        logic [4:0]    st;
        logic [AW-1:0] rid;
        logic          sy;
        logic          er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic [2:0] c, input logic [AW-1:0] r, input logic st,
                                input int n, input logic [4:0] e_st, input logic [AW-1:0] e_row,
                                input logic e_sy, input logic e_er);
        vec_t v;
        v.sel = s; v.cmd = c; v.row = r; v.stall = st; v.reps = n;
        v.st = e_st; v.rid = e_row; v.sy = e_sy; v.er = e_er;
        vecs.push_back(v);
    endfunction

    localparam logic [AW-1:0] RA = 17'h1A2B3;
    localparam logic [AW-1:0] RB = 17'h00055;

    initial begin
        reset = 1'b1;
        drive(1'b0, C_NOP, '0, 1'b0);

        // sel cmd row stall reps | state row sync err   (expected during that cycle)
        add(1, C_ACT, RA,      0, 1, S_IDLE, '0, 0, 0);
        add(0, C_NOP, '0,      0, 4, S_ACTG, RA, 0, 0);
        add(1, C_WR,  '0,      0, 1, S_ACT,  RA, 0, 0);
        add(0, C_NOP, '0,      0, 3, S_WR,   RA, 0, 0);
        add(0, C_NOP, '0,      0, 1, S_WR,   RA, 1, 0);
        add(0, C_NOP, '0,      0, 3, S_WR,   RA, 0, 0);
        add(1, C_RD,  '0,      0, 1, S_ACT,  RA, 0, 0);
        add(0, C_NOP, '0,      0, 4, S_RD,   RA, 0, 0);
        add(0, C_NOP, '0,      1, 3, S_RD,   RA, 0, 0);
        add(0, C_NOP, '0,      0, 1, S_RD,   RA, 1, 0);
        add(0, C_NOP, '0,      0, 3, S_RD,   RA, 0, 0);
        add(1, C_PRE, '0,      0, 1, S_ACT,  RA, 0, 0);
        add(0, C_NOP, '0,      1, 4, S_PRE,  RA, 0, 0);
        add(1, C_RD,  '0,      0, 1, S_IDLE, RA, 0, 0);
        add(0, C_NOP, '0,      0, 1, S_IDLE, RA, 0, 1);
        add(1, C_ACT, RB,      0, 1, S_IDLE, RA, 0, 0);
        add(1, C_ACT, 17'h0FFFF, 0, 1, S_ACTG, RB, 0, 0);
        add(0, C_NOP, '0,      1, 1, S_ACTG, RB, 0, 1);
        add(0, C_NOP, '0,      0, 1, S_ACTG, RB, 0, 0);
        add(1, C_RD,  '0,      0, 1, S_ACTG, RB, 0, 0);
        add(1, C_RD,  '0,      0, 1, S_ACT,  RB, 0, 1);
        add(1, C_WR,  '0,      0, 1, S_RD,   RB, 0, 0);
        add(0, C_NOP, '0,      0, 1, S_RD,   RB, 0, 1);
        add(0, C_NOP, '0,      0, 2, S_RD,   RB, 0, 0);
        add(0, C_NOP, '0,      0, 1, S_RD,   RB, 1, 0);
        add(0, C_NOP, '0,      0, 3, S_RD,   RB, 0, 0);
        add(1, C_PRE, '0,      0, 1, S_ACT,  RB, 0, 0);
        add(0, C_NOP, '0,      0, 4, S_PRE,  RB, 0, 0);
        add(1, C_REF, '0,      0, 1, S_IDLE, RB, 0, 0);
        add(0, C_NOP, '0,      1, 8, S_REF,  RB, 0, 0);
        add(1, C_REF, '0,      0, 1, S_IDLE, RB, 0, 0);
        add(1, C_ACT, RA,      0, 1, S_REF,  RB, 0, 0);
        add(0, C_NOP, '0,      0, 1, S_REF,  RB, 0, 1);

        @(negedge clk);
        do_reset();
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                step_exp(vecs[i].sel, vecs[i].cmd, vecs[i].row, vecs[i].stall,
                         vecs[i].st, vecs[i].rid, vecs[i].sy, vecs[i].er, $sformatf("vec%0d", i));
            end
        end

        // Reset in the middle of WRITING at k=2, then a clean ACT after release.
        do_reset();
        step_exp(1, C_ACT, 17'h12345, 0, S_IDLE, '0, 0, 0, "mid.act");
        for (int i = 0; i < TRCD; i++) step_exp(0, C_NOP, '0, 0, S_ACTG, 17'h12345, 0, 0, "mid.actg");
        step_exp(1, C_WR, '0, 0, S_ACT, 17'h12345, 0, 0, "mid.wr");
        step_exp(0, C_NOP, '0, 0, S_WR, 17'h12345, 0, 0, "mid.k0");
        step_exp(0, C_NOP, '0, 0, S_WR, 17'h12345, 0, 0, "mid.k1");
        drive(0, C_NOP, '0, 0);
        #1;
        chk("mid.k2.state", 32'(BankFSM), 32'(S_WR));
        #1;
        reset = 1'b1;
        #1;
        chk("mid.async.state", 32'(BankFSM), 32'h0);
        chk("mid.async.row",   32'(RowId),   32'h0);
        chk("mid.async.sync",  32'(sync),    32'h0);
        chk("mid.async.err",   32'(cmd_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step_exp(1, C_ACT, 17'h00ABC, 0, S_IDLE, '0, 0, 0, "post.act");
        step_exp(0, C_NOP, '0, 0, S_ACTG, 17'h00ABC, 0, 0, "post.actg");

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic          s;
            logic [2:0]    c;
            logic [AW-1:0] r;
            logic          st;
            s  = ($urandom % 4) != 0;
            c  = 3'($urandom % 8);
            r  = AW'($urandom);
            st = ($urandom % 3) == 0;
            step_model(s, c, r, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
